// File: rtl/alu_issue_sequencer.sv
// Issue/sequencing controller for the execute-stage ALU: single-cycle ops go through
// the external ALU, left shifts iterate one bit per cycle, results wait in HOLD.
module alu_issue_sequencer #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [4:0]         in_rd,
    output logic [3:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_err,
    output logic [4:0]         out_rd,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {IDLE, ALU, SHIFT, HOLD} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]         rd_q, rd_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               op_supported;

    assign op_supported = (op_q == OP_AND) || (op_q == OP_OR) ||
                          (op_q == OP_ADD) || (op_q == OP_SUB);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = in_op;
                    a_d  = in_a;
                    b_d  = in_b;
                    rd_d = in_rd;
                    if (in_op == OP_SLL) begin
                        sh_d    = in_a;
                        cnt_d   = in_b[SHAMT_W-1:0];
                        state_d = SHIFT;
                    end else begin
                        state_d = ALU;
                    end
                end
            end
            ALU: begin
                if (op_supported) begin
                    res_d  = alu_result;
                    zero_d = alu_zero;
                    err_d  = 1'b0;
                end else begin
                    res_d  = '0;
                    zero_d = 1'b1;
                    err_d  = 1'b1;
                end
                state_d = HOLD;
            end
            SHIFT: begin
                // Result is published on the edge where the remaining count is already zero.
                if (cnt_q != '0) begin
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q - SHAMT_W'(1);
                end else begin
                    res_d   = sh_q;
                    zero_d  = (sh_q == '0);
                    err_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == HOLD);
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;
    assign out_rd     = rd_q;
    assign op_count   = count_q;

endmodule

// File: doc/alu_issue_sequencer.md
# alu_issue_sequencer

Issue-and-sequencing controller for the execute-stage ALU. It accepts one decoded operation at a time over a valid/ready handshake and drives the combinational ALU for single-cycle operations (AND, OR, ADD, SUB). Left shifts (slli/sll) run internally as an iterative 1-bit-per-cycle shifter. Each result is held on an output handshake until the pipeline consumes it, and `busy` stalls upstream issue while an operation is in flight.

## Interface
- `WIDTH`, 64: datapath width in bits.
- `SHAMT_W`, 6: shift-amount width; shift amount is `in_b[SHAMT_W-1:0]`.
- `CNT_W`, 16: width of the completed-operation counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  the block can accept an operation; equals (state == IDLE).
- `in_op`  in  4  ALU Operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 SLL.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_rd`  in  5  destination register tag, passed through to `out_rd`.
- `alu_op`  out  4  operation code to the external ALU (captured value).
- `alu_a`, `alu_b`  out  WIDTH  operands to the external ALU (captured values).
- `alu_result`  in  WIDTH  external ALU result (combinational).
- `alu_zero`  in  1  external ALU zero flag.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  WIDTH  result.
- `out_zero`  out  1  result == 0.
- `out_err`  out  1  the completed operation had an unsupported `in_op`.
- `out_rd`  out  5  destination tag of the result.
- `busy`  out  1  state != IDLE.
- `op_count`  out  CNT_W  number of completed handshakes; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, ALU, SHIFT, HOLD.
- IDLE: `in_ready` = 1. An accept occurs on `in_valid & in_ready` at a rising edge. On accept, capture `in_op`, `in_a`, `in_b` and `in_rd`, then:
  - `in_op` = 1000: load shift register with `in_a`, load count with `in_b[SHAMT_W-1:0]`, go to SHIFT.
  - Any other `in_op`: go to ALU.
- ALU (exactly one cycle): the external ALU sees the captured op and operands.
  - Supported op: at the edge, capture `alu_result` into `out_result` and `alu_zero` into `out_zero`; `out_err` = 0.
  - Unsupported op: `out_result` = 0, `out_zero` = 1, `out_err` = 1.
  - Go to HOLD.
- SHIFT: at each edge with count != 0, shift register <<= 1 (zero fill) and count -= 1. At the edge with count == 0, `out_result` = shift register, `out_zero` = (shift register == 0), `out_err` = 0, go to HOLD.
- HOLD: `out_valid` = 1. Outputs stay stable until an edge with `out_ready` = 1. At that edge: go to IDLE, `op_count` += 1 (wraps).
- `alu_op`/`alu_a`/`alu_b` are driven from the capture registers at all times. They are meaningful only in ALU.
- Shift bits above WIDTH are discarded. `in_b` bits at and above SHAMT_W are ignored for shifts.
- Reset values:
  - state = IDLE.
  - `out_valid`, `out_result`, `out_zero`, `out_err`, `out_rd`, `op_count`, `alu_op`, `alu_a`, `alu_b` = 0.
  - `in_ready` = 1, `busy` = 0.
- Reset asserted mid-operation: the operation is dropped with no completion; `op_count` clears.

## Timing
- Accept at edge N. ALU op: `out_valid` = 1 after edge N+1. Shift with amount s: `out_valid` = 1 after edge N+1+s (s = 0 behaves like an ALU op).
- Result is consumed at the first edge M with `out_ready` = 1 while in HOLD. `in_ready` = 1 after M; the next accept is possible at edge M+1.
- No back-to-back issue. Maximum throughput is one operation per 3 cycles.
- `out_ready` outside HOLD is ignored. `in_valid` outside IDLE is ignored; upstream must hold the operation until `in_ready` is 1.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` never depends combinationally on `in_valid`.

## Test plan
- Reset pulse mid-SHIFT (accept SLL with s = 40, assert `reset` 10 cycles later) -> `out_valid` = 0, `busy` = 0, `in_ready` = 1 and `op_count` = 0 immediately, asynchronously.
- ADD: a = 5, b = 7, rd = 3, `out_ready` held high -> `out_valid` after edge N+1 with `out_result` = 12, `out_zero` = 0, `out_rd` = 3; `op_count` = 1 after the consume edge.
- SUB: a = b = 0x1234 -> `out_result` = 0, `out_zero` = 1. AND 0xF0 & 0x3C -> 0x30. OR 0xF0 | 0x0F -> 0xFF.
- SLL: a = 1, b = 63 -> `out_valid` exactly after edge N+64 with `out_result` = 0x8000_0000_0000_0000. SLL with b = 0x40 (s = 0) -> after N+1, result 1.
- Back-pressure: ADD completes with `out_ready` low for 5 cycles -> outputs stable, `in_ready` = 0, second `in_valid` ignored. Raise `out_ready` -> the next accept is at the following edge.
- Unsupported op 0101 -> `out_err` = 1, `out_result` = 0, `out_zero` = 1. After 2^16 completions, `op_count` wraps to 0.
